// File: rtl/asg_pkg.sv
// Shared types and constants for the ASG keystream sequencer.
package asg_pkg;

  localparam int ASG_NUM_REGS = 3;
  localparam int ASG_BYTE_W   = 8;

  typedef logic [2:0] asg_state_t;

  localparam asg_state_t ST_IDLE = 3'd0;
  localparam asg_state_t ST_LOAD = 3'd1;
  localparam asg_state_t ST_WARM = 3'd2;
  localparam asg_state_t ST_RUN  = 3'd3;
  localparam asg_state_t ST_HOLD = 3'd4;

endpackage

// File: rtl/asg_bit_packer.sv
// Serial-to-parallel packer: shifts bits in MSB first, flags a completed word
// and can retain it (full) until the sequencer drains it.
module asg_bit_packer #(
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              bit_in,
  input  logic              hold_word,
  input  logic              drain,
  output logic [BYTE_W-1:0] word,
  output logic [BYTE_W-1:0] word_next,
  output logic              done,
  output logic              full
);

  localparam int CW = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

  logic [CW-1:0] bit_cnt;

  // word_next is the completed word on the cycle the last bit arrives
  assign word_next = {word[BYTE_W-2:0], bit_in};
  assign done      = shift_en && (bit_cnt == CW'(BYTE_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word    <= '0;
      bit_cnt <= '0;
      full    <= 1'b0;
    end else if (clear) begin
      word    <= '0;
      bit_cnt <= '0;
      full    <= 1'b0;
    end else if (drain) begin
      word <= '0;
      full <= 1'b0;
    end else if (shift_en) begin
      bit_cnt <= done ? '0 : bit_cnt + CW'(1);
      if (done && !hold_word) begin
        word <= '0;
      end else begin
        word <= word_next;
      end
      if (done && hold_word) begin
        full <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/asg_sequencer.sv
// Sequences ASG register load, warm-up and keystream run, packing ASG output
// bits into words behind a valid/ready output register.
module asg_sequencer
  import asg_pkg::*;
#(
  parameter int WARMUP_W = 8,
  parameter int BYTE_W   = ASG_BYTE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [WARMUP_W-1:0] warmup,
  output logic [1:0]          asg_load_sel,
  output logic                asg_load,
  output logic                asg_enable,
  input  logic                asg_bit,
  output logic [BYTE_W-1:0]   byte_data,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic                busy,
  output asg_state_t          dbg_state
);

  // Output handshake: a word transfers on a rising edge where byte_valid and
  // byte_ready are both 1; byte_data is held stable while valid and not ready.

  asg_state_t          state;
  asg_state_t          state_nxt;
  logic [WARMUP_W-1:0] warm_cnt;
  logic [1:0]          load_idx;

  logic                handshake;
  logic                out_free;
  logic                pk_shift;
  logic                pk_drain;
  logic                pk_done;
  logic                pk_full;
  logic [BYTE_W-1:0]   pk_word;
  logic [BYTE_W-1:0]   pk_word_next;
  logic                load_word;

  assign handshake = byte_valid && byte_ready;
  assign out_free  = !byte_valid || byte_ready;
  assign pk_shift  = (state == ST_RUN);
  assign pk_drain  = (state == ST_HOLD) && byte_ready;
  assign load_word = !stop && (((state == ST_RUN) && pk_done && out_free) || pk_drain);

  asg_bit_packer #(
    .BYTE_W (BYTE_W)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (stop),
    .shift_en  (pk_shift),
    .bit_in    (asg_bit),
    .hold_word (!out_free),
    .drain     (pk_drain),
    .word      (pk_word),
    .word_next (pk_word_next),
    .done      (pk_done),
    .full      (pk_full)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (load_idx == 2'(ASG_NUM_REGS - 1)) begin
          state_nxt = (warm_cnt == '0) ? ST_RUN : ST_WARM;
        end
      end
      ST_WARM: if (warm_cnt == WARMUP_W'(1)) state_nxt = ST_RUN;
      ST_RUN:  if (pk_done && !out_free) state_nxt = ST_HOLD;
      ST_HOLD: if (byte_ready && pk_full) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
    // abort wins over everything, including a start in IDLE
    if (stop) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      warm_cnt <= '0;
      load_idx <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            warm_cnt <= warmup;
            load_idx <= '0;
          end
        end
        ST_LOAD: load_idx <= (load_idx == 2'(ASG_NUM_REGS - 1)) ? 2'd0 : load_idx + 2'd1;
        ST_WARM: warm_cnt <= warm_cnt - WARMUP_W'(1);
        default: ;
      endcase
    end
  end

  // Output register: a fresh word may replace an accepted one in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_data  <= '0;
      byte_valid <= 1'b0;
    end else if (load_word) begin
      byte_data  <= (state == ST_HOLD) ? pk_word : pk_word_next;
      byte_valid <= 1'b1;
    end else if (handshake) begin
      byte_valid <= 1'b0;
    end
  end

  assign asg_load     = (state == ST_LOAD);
  assign asg_load_sel = (state == ST_LOAD) ? load_idx : 2'd0;
  assign asg_enable   = (state == ST_WARM) || (state == ST_RUN);
  assign busy         = (state != ST_IDLE);
  assign dbg_state    = state;

endmodule

// File: tb/tb_asg_sequencer.sv
// Bench for asg_sequencer: queue-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed words and latencies.
module tb_asg_sequencer;

  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [7:0]    warmup = 8'd0;
  logic          asg_bit = 1'b0;
  logic          byte_ready = 1'b0;
  logic [1:0]    asg_load_sel;
  logic          asg_load;
  logic          asg_enable;
  logic [BW-1:0] byte_data;
  logic          byte_valid;
  logic          busy;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [BW-1:0] exp_q[$];
  logic          pat_q[$];

  asg_sequencer #(.WARMUP_W(8), .BYTE_W(BW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .warmup       (warmup),
    .asg_load_sel (asg_load_sel),
    .asg_load     (asg_load),
    .asg_enable   (asg_enable),
    .asg_bit      (asg_bit),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase 0 idle, 1 load, 2 warm-up, 3 keystream; a stall is simply a full
  // packer (8 bits collected) waiting for the output word to be taken.
  int            m_phase = 0;
  int            m_cnt = 0;
  int            m_w = 0;
  logic [BW-1:0] m_pk = '0;
  int            m_pkn = 0;
  logic          m_ov = 1'b0;
  logic [BW-1:0] m_od = '0;
  logic          m_new = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_w = 0; m_pk = '0; m_pkn = 0;
      m_ov = 1'b0; m_od = '0; m_new = 1'b0;
    end else begin
      logic hs;
      hs = m_ov && byte_ready;
      m_new = 1'b0;
      if (stop) begin
        m_phase = 0; m_pkn = 0; m_pk = '0;
      end else begin
        case (m_phase)
          0: if (start) begin m_phase = 1; m_cnt = 0; m_w = int'(warmup); end
          1: begin
            m_cnt++;
            if (m_cnt == 3) begin m_cnt = 0; m_phase = (m_w == 0) ? 3 : 2; end
          end
          2: begin
            m_cnt++;
            if (m_cnt == m_w) begin m_cnt = 0; m_phase = 3; end
          end
          default: begin
            if (m_pkn < BW) begin m_pk = {m_pk[BW-2:0], asg_bit}; m_pkn++; end
            if (m_pkn == BW && (!m_ov || hs)) begin
              m_od = m_pk; m_ov = 1'b1; m_pkn = 0; m_new = 1'b1; hs = 1'b0;
            end
          end
        endcase
      end
      if (hs) m_ov = 1'b0;
    end
  end

  // ---------------- per-cycle compare + bit source ----------------
  initial forever begin
    @(negedge clk);
    chk("asg_load", 32'(asg_load), 32'(m_phase == 1));
    chk("asg_load_sel", 32'(asg_load_sel), 32'((m_phase == 1) ? m_cnt : 0));
    chk("asg_enable", 32'(asg_enable), 32'((m_phase == 2) || (m_phase == 3 && m_pkn < BW)));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("byte_valid", 32'(byte_valid), 32'(m_ov));
    chk("byte_data", 32'(byte_data), 32'(m_od));
    if (m_new) begin
      if (exp_q.size() > 0) chk("sb_word", 32'(byte_data), 32'(exp_q.pop_front()));
      m_new = 1'b0;
    end
    // warm-up bits are forced to 1 so any leak into a word is visible
    if (m_phase == 3 && m_pkn < BW && pat_q.size() > 0) asg_bit = pat_q.pop_front();
    else if (m_phase == 2) asg_bit = 1'b1;
    else asg_bit = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_word(input logic [BW-1:0] w);
    for (int i = BW - 1; i >= 0; i--) pat_q.push_back(w[i]);
    exp_q.push_back(w);
  endtask

  task automatic do_start(input logic [7:0] w);
    @(negedge clk);
    warmup = w;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic do_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output int n);
    n = 0;
    while (!byte_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!byte_valid) chk("wait_valid_timeout", 32'(byte_valid), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_enable"}, 32'(asg_enable), 32'd0);
    chk({tag, "_load"}, 32'(asg_load), 32'd0);
    chk({tag, "_sel"}, 32'(asg_load_sel), 32'd0);
    chk({tag, "_valid"}, 32'(byte_valid), 32'd0);
    chk({tag, "_data"}, 32'(byte_data), 32'd0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);

    // warmup 0: 3 load cycles, then 1,0,1,1,0,0,1,0 packs to 0xB2
    byte_ready = 1'b1;
    push_word(8'hB2);
    do_start(8'd0);
    #1 chk("t1_load0", 32'(asg_load), 32'd1);
    chk("t1_sel0", 32'(asg_load_sel), 32'd0);
    cyc(1); #1 chk("t1_sel1", 32'(asg_load_sel), 32'd1);
    cyc(1); #1 chk("t1_sel2", 32'(asg_load_sel), 32'd2);
    cyc(1); #1 chk("t1_enable", 32'(asg_enable), 32'd1);
    chk("t1_load_off", 32'(asg_load), 32'd0);
    cyc(8); #1 chk("t1_valid", 32'(byte_valid), 32'd1);
    chk("t1_word", 32'(byte_data), 32'hB2);
    cyc(1); #1 chk("t1_valid_one_cycle", 32'(byte_valid), 32'd0);
    do_stop();
    #1 chk("t1_idle", 32'(busy), 32'd0);

    // warmup 5: first word 3+5+8 cycles after start is accepted, warm-up bits ignored
    push_word(8'h96);
    do_start(8'd5);
    wait_valid(40, n);
    chk("t2_latency", 32'(n), 32'd16);
    #1 chk("t2_word", 32'(byte_data), 32'h96);
    do_stop();

    // stall: consumer not ready, second word fills the packer and the ASG is paused
    byte_ready = 1'b0;
    push_word(8'hA5);
    push_word(8'h3C);
    push_word(8'h0F);
    do_start(8'd0);
    cyc(21);
    #1 chk("t3_held_word", 32'(byte_data), 32'hA5);
    chk("t3_held_valid", 32'(byte_valid), 32'd1);
    chk("t3_hold_enable", 32'(asg_enable), 32'd0);
    chk("t3_hold_busy", 32'(busy), 32'd1);
    byte_ready = 1'b1;
    cyc(1); #1 chk("t3_second_word", 32'(byte_data), 32'h3C);
    chk("t3_second_valid", 32'(byte_valid), 32'd1);
    cyc(1); #1 chk("t3_drained", 32'(byte_valid), 32'd0);
    wait_valid(20, n);
    #1 chk("t3_third_word", 32'(byte_data), 32'h0F);
    do_stop();
    chk("t3_sb_empty", 32'(exp_q.size()), 32'd0);

    // stop after 4 keystream bits, then a fresh start must not reuse them
    for (int i = 0; i < 4; i++) pat_q.push_back(1'b1);
    do_start(8'd0);
    cyc(7);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    #1 chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_enable", 32'(asg_enable), 32'd0);
    chk("t4_valid", 32'(byte_valid), 32'd0);
    push_word(8'h81);
    do_start(8'd0);
    wait_valid(30, n);
    chk("t4_latency", 32'(n), 32'd11);
    #1 chk("t4_fresh_word", 32'(byte_data), 32'h81);
    do_stop();

    // asynchronous reset during warm-up
    do_start(8'd10);
    cyc(5);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("t5_warm_rst");
    pat_q.delete();
    exp_q.delete();
    cyc(2);
    #2 rst_n = 1'b1;
    cyc(2);
    #1 chk("t5_idle_after_rst", 32'(busy), 32'd0);

    // asynchronous reset while stalled with a pending word
    byte_ready = 1'b0;
    push_word(8'h5A);
    push_word(8'hC3);
    do_start(8'd0);
    cyc(21);
    #1 chk("t5_hold_enable", 32'(asg_enable), 32'd0);
    chk("t5_hold_valid", 32'(byte_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("t5_hold_rst");
    pat_q.delete();
    exp_q.delete();
    cyc(2);
    #2 rst_n = 1'b1;
    byte_ready = 1'b1;
    cyc(3);
    #1 chk("t5_no_autostart", 32'(busy), 32'd0);
    chk("t5_no_word", 32'(byte_valid), 32'd0);

    // start while busy is ignored (warmup 7 must not be latched)
    push_word(8'hE7);
    do_start(8'd0);
    warmup = 8'd7;
    start  = 1'b1;
    cyc(1);
    start  = 1'b0;
    wait_valid(30, n);
    chk("t6_latency", 32'(n), 32'd10);
    #1 chk("t6_word", 32'(byte_data), 32'hE7);
    do_stop();

    // start and stop together in IDLE: stay idle
    cyc(2);
    start = 1'b1;
    stop  = 1'b1;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    #1 chk("t7_idle", 32'(busy), 32'd0);
    cyc(2);
    #1 chk("t7_still_idle", 32'(busy), 32'd0);
    chk("t7_sb_empty", 32'(exp_q.size()), 32'd0);

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/asg_sequencer.md
ASG_SEQUENCER -- requirements
Module: asg_sequencer

Interface
REQ-001 Parameter: WARMUP_W, default 8, width of warm-up cycle count.
REQ-002 Parameter: BYTE_W, default 8, bits packed per output word.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request to begin a load/warm-up/run sequence.
REQ-006 stop  in  1  abort request; returns block to IDLE.
REQ-007 warmup  in  WARMUP_W  number of ASG steps discarded after load; sampled on accepted start.
REQ-008 asg_load_sel  out  2  selects the ASG register being loaded (0,1,2).
REQ-009 asg_load  out  1  load strobe to ASG.
REQ-010 asg_enable  out  1  step enable to ASG.
REQ-011 asg_bit  in  1  ASG output bit; valid in any cycle where asg_enable=1.
REQ-012 byte_data  out  BYTE_W  packed keystream word.
REQ-013 byte_valid  out  1  byte_data holds an unconsumed word.
REQ-014 byte_ready  in  1  consumer accepts word when byte_valid=1 and byte_ready=1 at a rising edge.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, WARM, RUN, HOLD.
REQ-017 IDLE: start=1 and stop=0 -> LOAD; warmup latched into internal counter; load index cleared to 0.
REQ-018 LOAD SHALL last exactly 3 cycles with asg_load=1, asg_enable=0, asg_load_sel=0,1,2 in successive cycles.
REQ-019 After LOAD: latched warmup=0 -> RUN directly; else -> WARM.
REQ-020 WARM SHALL hold asg_enable=1 for exactly warmup cycles, discard asg_bit, then -> RUN.
REQ-021 RUN SHALL hold asg_enable=1 and shift asg_bit into a BYTE_W-bit packer each cycle, MSB first (first bit -> byte_data[BYTE_W-1]).
REQ-022 Packer full and output register empty or handshaking in the same cycle: word moves to byte_data, byte_valid=1 on next cycle; packing continues without a gap.
REQ-023 Packer full and output register holding an unaccepted word: -> HOLD, asg_enable=0, no bits captured.
REQ-024 HOLD: on handshake, packer word transfers to byte_data at that edge, byte_valid stays 1, -> RUN.
REQ-025 byte_valid SHALL drop only after a handshake with no new word transferring; byte_data SHALL be stable while byte_valid=1 and byte_ready=0.
REQ-026 Sustained byte_ready=1: one word per BYTE_W cycles, first byte_valid exactly BYTE_W cycles after RUN entry.
REQ-027 stop=1 in any state -> IDLE next cycle; asg_load and asg_enable low from that cycle; partial packer contents discarded; a word already in byte_data retained until accepted.
REQ-028 start while busy=1 SHALL be ignored; start and stop together in IDLE: stop wins, remain IDLE.
REQ-029 Sequence runs indefinitely until stop or reset; packer bit counter wraps BYTE_W-1 -> 0.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, all counters 0, packer and byte_data 0, byte_valid, busy, asg_load, asg_enable, asg_load_sel all 0.
REQ-031 Reset mid-sequence SHALL discard all data including a pending byte_data word; first action after release requires a new start.

Structure
REQ-032 Shared package asg_pkg SHALL hold the FSM state type, ASG_NUM_REGS=3 and default BYTE_W.
REQ-033 One sub-module asg_bit_packer (shift register, bit counter, full flag) SHALL be instantiated; FSM and output register stay in asg_sequencer.

Verification
REQ-034 start, warmup=0, byte_ready=1 -> asg_load 1 for 3 cycles with sel 0,1,2, then asg_enable=1; asg_bit pattern 1,0,1,1,0,0,1,0 -> byte_data=0xB2, byte_valid 1 for one cycle.
REQ-035 start, warmup=5 -> asg_enable high 5 cycles with bits ignored before first packed bit; first byte_valid 3+5+8 cycles after start.
REQ-036 byte_ready=0 for 20 cycles in RUN -> first word held stable, second word fills packer, HOLD with asg_enable=0; byte_ready=1 -> two consecutive words delivered in order, no bit lost.
REQ-037 stop after 4 RUN bits -> IDLE next cycle, busy=0, asg_enable=0; next start yields a full fresh word with no stale bits.
REQ-038 rst_n low in WARM and in HOLD -> all outputs 0 immediately (asynchronously), byte_valid=0; start during busy and start+stop in IDLE both ignored.
